// File: rtl/fetch_pkg.sv
// Shared fetch-stage types: FSM state encoding and the default {pc, instr} prefetch entry.
package fetch_pkg;

    localparam int INSTR_W      = 32;
    localparam int DEFAULT_XLEN = 32;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DROP
    } fetch_state_t;

    // Layout at the default XLEN; the top re-declares it when XLEN is overridden.
    typedef struct packed {
        logic [DEFAULT_XLEN-1:0] pc;
        logic [INSTR_W-1:0]      instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous prefetch FIFO with synchronous flush; head is read straight from storage.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = fetch_entry_t
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic                  pop,
    input  logic                  flush,
    input  entry_t                din,
    output logic [$clog2(DEPTH):0] count,
    output entry_t                head
);

    localparam int PW = $clog2(DEPTH);

    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    entry_t        mem [DEPTH];

    // NOTE: storage carries no reset; only pointers and count do, and head is qualified by count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= din;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_prefetch_unit.sv
// Fetch stage: one-outstanding-request instruction fetcher feeding a prefetch FIFO,
// with redirect flush and discard of the in-flight response.
module fetch_prefetch_unit
    import fetch_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req_valid,
    input  logic               imem_req_ready,
    output logic [XLEN-1:0]    imem_req_addr,
    input  logic               imem_rsp_valid,
    input  logic [INSTR_W-1:0] imem_rsp_data,
    input  logic               redirect,
    input  logic [XLEN-1:0]    redirect_pc,
    input  logic               stall_d,
    output logic               instr_valid,
    output logic [INSTR_W-1:0] instr,
    output logic [XLEN-1:0]    pc,
    output logic [XLEN-1:0]    pc_plus4
);

    localparam int CW = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [XLEN-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } entry_t;

    fetch_state_t    state;
    fetch_state_t    state_next;
    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] fetch_pc_next;
    logic [CW-1:0]   count;
    logic            space;
    logic            req_valid;
    logic            push;
    logic            pop;
    entry_t          push_entry;
    entry_t          head;

    // Space is checked at issue time, so the single outstanding response always has a slot.
    assign space = (count < CW'(DEPTH));

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_next    = state;
        fetch_pc_next = fetch_pc;
        req_valid     = 1'b0;
        push          = 1'b0;
        case (state)
            IDLE: begin
                req_valid = space && !redirect;
                if (req_valid && imem_req_ready) begin
                    fetch_pc_next = fetch_pc + XLEN'(4);
                    state_next    = WAIT;
                end
            end
            WAIT: begin
                if (imem_rsp_valid) begin
                    push       = !redirect;
                    state_next = IDLE;
                end else if (redirect) begin
                    state_next = DROP;
                end
            end
            DROP: begin
                if (imem_rsp_valid) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        if (redirect) begin
            fetch_pc_next = {redirect_pc[XLEN-1:2], 2'b00};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            fetch_pc <= {RESET_PC[XLEN-1:2], 2'b00};
        end else begin
            state    <= state_next;
            fetch_pc <= fetch_pc_next;
        end
    end

    // Reset only masks the port; the internal request term never reaches a flop while rst is low.
    assign imem_req_valid = req_valid & rst;
    assign imem_req_addr  = fetch_pc;

    // fetch_pc already advanced at accept time, so the returning word belongs to fetch_pc-4.
    assign push_entry.pc    = fetch_pc - XLEN'(4);
    assign push_entry.instr = imem_rsp_data;

    assign instr_valid = (count != '0);
    assign pop         = instr_valid && !stall_d && !redirect;

    fetch_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (redirect),
        .din   (push_entry),
        .count (count),
        .head  (head)
    );

    assign instr    = head.instr;
    assign pc       = head.pc;
    assign pc_plus4 = head.pc + XLEN'(4);

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Directed bench for fetch_prefetch_unit with a variable-latency memory model (data = ~addr).
module tb_fetch_prefetch_unit;

    logic        clk;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        stall_d;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;

    int passed = 0;
    int total  = 0;

    int          mem_lat = 1;
    logic        pend;
    logic [31:0] pend_addr;
    int          pend_cnt;

    fetch_prefetch_unit #(
        .XLEN     (32),
        .DEPTH    (4),
        .RESET_PC (32'h0)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .stall_d        (stall_d),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .pc             (pc),
        .pc_plus4       (pc_plus4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory: captures an accepted request mid-cycle, answers mem_lat cycles later; reset drops it.
    initial begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        pend           = 1'b0;
        pend_addr      = '0;
        pend_cnt       = 0;
        forever begin
            @(posedge clk);
            #1;
            imem_rsp_valid = 1'b0;
            if (pend) begin
                pend_cnt = pend_cnt - 1;
                if (pend_cnt == 0) begin
                    imem_rsp_valid = 1'b1;
                    imem_rsp_data  = ~pend_addr;
                    pend           = 1'b0;
                end
            end
            @(negedge clk);
            if (!rst) begin
                pend = 1'b0;
            end else if (imem_req_valid && imem_req_ready) begin
                pend      = 1'b1;
                pend_addr = imem_req_addr;
                pend_cnt  = mem_lat;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench at the drive point of the first cycle out of reset (c0).
    task automatic reset_dut();
        redirect    = 1'b0;
        redirect_pc = '0;
        rst         = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic test_reset();
        mem_lat = 1; imem_req_ready = 1'b1; stall_d = 1'b0; redirect = 1'b0; redirect_pc = '0;
        rst = 1'b0;
        @(negedge clk);
        total++; if (imem_req_valid !== 1'b0) $display("FAIL rst_req_valid: got %b want 0", imem_req_valid); else passed++;
        total++; if (instr_valid !== 1'b0) $display("FAIL rst_instr_valid: got %b want 0", instr_valid); else passed++;
        adv(); rst = 1'b1;
        @(negedge clk);
        total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) $display("FAIL t1_first_req: got v=%b a=%h want v=1 a=00000000", imem_req_valid, imem_req_addr); else passed++;
        adv(); @(negedge clk);
        total++; if (imem_req_valid !== 1'b0 || instr_valid !== 1'b0) $display("FAIL t1_wait: got req=%b iv=%b want 0 0", imem_req_valid, instr_valid); else passed++;
        adv(); @(negedge clk);
        total++; if (instr_valid !== 1'b1 || pc !== 32'h0 || instr !== 32'hFFFF_FFFF) $display("FAIL t1_head0: got iv=%b pc=%h instr=%h want 1 00000000 ffffffff", instr_valid, pc, instr); else passed++;
        total++; if (pc_plus4 !== 32'h4) $display("FAIL t1_pc_plus4: got %h want 00000004", pc_plus4); else passed++;
        total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h4) $display("FAIL t1_second_req: got v=%b a=%h want 1 00000004", imem_req_valid, imem_req_addr); else passed++;
        adv(); adv(); @(negedge clk);
        total++; if (instr_valid !== 1'b1 || pc !== 32'h4 || instr !== 32'hFFFF_FFFB) $display("FAIL t1_head1: got iv=%b pc=%h instr=%h want 1 00000004 fffffffb", instr_valid, pc, instr); else passed++;
        total++; if (imem_req_addr !== 32'h8 || imem_req_valid !== 1'b1) $display("FAIL t1_third_req: got v=%b a=%h want 1 00000008", imem_req_valid, imem_req_addr); else passed++;
    endtask

    task automatic test_stall_fill();
        logic [31:0] exp_pc [5] = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10};
        mem_lat = 1; imem_req_ready = 1'b1; stall_d = 1'b1;
        reset_dut();
        repeat (8) adv();
        @(negedge clk);
        total++; if (imem_req_valid !== 1'b0) $display("FAIL t2_full_no_req: got %b want 0", imem_req_valid); else passed++;
        total++; if (instr_valid !== 1'b1 || pc !== 32'h0) $display("FAIL t2_full_head: got iv=%b pc=%h want 1 00000000", instr_valid, pc); else passed++;
        adv(); adv(); @(negedge clk);
        total++; if (imem_req_valid !== 1'b0 || pc !== 32'h0 || instr !== 32'hFFFF_FFFF) $display("FAIL t2_stall_hold: got req=%b pc=%h instr=%h want 0 00000000 ffffffff", imem_req_valid, pc, instr); else passed++;
        adv(); stall_d = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total++; if (instr_valid !== 1'b1 || pc !== exp_pc[i]) $display("FAIL t2_drain%0d: got iv=%b pc=%h want 1 %h", i, instr_valid, pc, exp_pc[i]); else passed++;
            if (i == 0) begin
                total++; if (imem_req_valid !== 1'b0) $display("FAIL t2_still_full: got %b want 0", imem_req_valid); else passed++;
            end
            if (i == 1) begin
                total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h10) $display("FAIL t2_resume: got v=%b a=%h want 1 00000010", imem_req_valid, imem_req_addr); else passed++;
            end
            adv();
        end
    endtask

    task automatic test_redirect_wait();
        logic seen_valid;
        logic got_req;
        logic got_head;
        mem_lat = 5; imem_req_ready = 1'b1; stall_d = 1'b0;
        reset_dut();
        adv(); adv();
        redirect = 1'b1; redirect_pc = 32'h100;
        @(negedge clk);
        total++; if (imem_req_valid !== 1'b0) $display("FAIL t3_no_req_in_wait: got %b want 0", imem_req_valid); else passed++;
        adv(); redirect = 1'b0;
        @(negedge clk);
        total++; if (instr_valid !== 1'b0 || imem_req_valid !== 1'b0) $display("FAIL t3_flushed: got iv=%b req=%b want 0 0", instr_valid, imem_req_valid); else passed++;
        seen_valid = 1'b0; got_req = 1'b0;
        for (int i = 0; i < 20 && !got_req; i++) begin
            adv(); @(negedge clk);
            if (instr_valid) seen_valid = 1'b1;
            if (imem_req_valid) got_req = 1'b1;
        end
        total++; if (!got_req || imem_req_addr !== 32'h100) $display("FAIL t3_new_req: got seen=%b a=%h want 1 00000100", got_req, imem_req_addr); else passed++;
        total++; if (seen_valid !== 1'b0) $display("FAIL t3_stale_head: got %b want 0", seen_valid); else passed++;
        got_head = 1'b0;
        for (int i = 0; i < 20 && !got_head; i++) begin
            adv(); @(negedge clk);
            if (instr_valid) got_head = 1'b1;
        end
        total++; if (!got_head || pc !== 32'h100 || instr !== 32'hFFFF_FEFF) $display("FAIL t3_first_head: got iv=%b pc=%h instr=%h want 1 00000100 fffffeff", got_head, pc, instr); else passed++;
    endtask

    task automatic test_redirect_idle();
        int          k;
        logic [31:0] exp;
        mem_lat = 2; imem_req_ready = 1'b1; stall_d = 1'b0;
        reset_dut();
        adv(); adv(); adv();
        redirect = 1'b1; redirect_pc = 32'h203;
        @(negedge clk);
        total++; if (imem_req_valid !== 1'b0) $display("FAIL t4_req_suppressed: got %b want 0", imem_req_valid); else passed++;
        total++; if (instr_valid !== 1'b1 || pc !== 32'h0) $display("FAIL t4_head_before_flush: got iv=%b pc=%h want 1 00000000", instr_valid, pc); else passed++;
        adv(); redirect = 1'b0;
        @(negedge clk);
        total++; if (instr_valid !== 1'b0) $display("FAIL t4_flushed: got %b want 0", instr_valid); else passed++;
        total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h200) $display("FAIL t4_next_req: got v=%b a=%h want 1 00000200", imem_req_valid, imem_req_addr); else passed++;
        k = 0;
        for (int i = 0; i < 40 && k < 3; i++) begin
            adv(); @(negedge clk);
            if (instr_valid) begin
                exp = 32'h200 + 32'(4 * k);
                total++; if (pc !== exp) $display("FAIL t4_head%0d: got pc=%h want %h", k, pc, exp); else passed++;
                k++;
            end
        end
        total++; if (k != 3) $display("FAIL t4_heads_seen: got %0d want 3", k); else passed++;
    endtask

    task automatic test_backpressure();
        mem_lat = 1; imem_req_ready = 1'b0; stall_d = 1'b0;
        reset_dut();
        for (int i = 0; i < 4; i++) begin
            if (i == 3) imem_req_ready = 1'b1;
            @(negedge clk);
            total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) $display("FAIL t5_hold%0d: got v=%b a=%h want 1 00000000", i, imem_req_valid, imem_req_addr); else passed++;
            adv();
        end
        @(negedge clk);
        total++; if (imem_req_valid !== 1'b0) $display("FAIL t5_wait: got %b want 0", imem_req_valid); else passed++;
        adv(); @(negedge clk);
        total++; if (instr_valid !== 1'b1 || pc !== 32'h0) $display("FAIL t5_head: got iv=%b pc=%h want 1 00000000", instr_valid, pc); else passed++;
        total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h4) $display("FAIL t5_advance4: got v=%b a=%h want 1 00000004", imem_req_valid, imem_req_addr); else passed++;
    endtask

    task automatic test_reset_mid_wait();
        logic got_head;
        mem_lat = 3; imem_req_ready = 1'b1; stall_d = 1'b1;
        reset_dut();
        repeat (8) adv();
        @(negedge clk);
        total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8 || pc !== 32'h0) $display("FAIL t6_setup: got v=%b a=%h pc=%h want 1 00000008 00000000", imem_req_valid, imem_req_addr, pc); else passed++;
        adv(); @(negedge clk);
        total++; if (instr_valid !== 1'b1 || imem_req_valid !== 1'b0) $display("FAIL t6_in_wait: got iv=%b req=%b want 1 0", instr_valid, imem_req_valid); else passed++;
        #1 rst = 1'b0;
        #1;
        total++; if (instr_valid !== 1'b0 || imem_req_valid !== 1'b0) $display("FAIL t6_async_drop: got iv=%b req=%b want 0 0", instr_valid, imem_req_valid); else passed++;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1; stall_d = 1'b0;
        @(negedge clk);
        total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) $display("FAIL t6_refetch: got v=%b a=%h want 1 00000000", imem_req_valid, imem_req_addr); else passed++;
        got_head = 1'b0;
        for (int i = 0; i < 20 && !got_head; i++) begin
            adv(); @(negedge clk);
            if (instr_valid) got_head = 1'b1;
        end
        total++; if (!got_head || pc !== 32'h0 || instr !== 32'hFFFF_FFFF) $display("FAIL t6_first_head: got iv=%b pc=%h instr=%h want 1 00000000 ffffffff", got_head, pc, instr); else passed++;
    endtask

    initial begin
        rst = 1'b0; imem_req_ready = 1'b0; redirect = 1'b0; redirect_pc = '0; stall_d = 1'b0;
        test_reset();
        test_stall_fill();
        test_redirect_wait();
        test_redirect_idle();
        test_backpressure();
        test_reset_mid_wait();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
